// File: rtl/uart_tx_sched.sv
// uart_tx_sched: drains a first-word-fall-through TX FIFO into a UART
// serializer, one word per frame, with an optional idle gap after each frame.
//
// Ports:
//   clk, rst       system clock; synchronous active-high reset
//   enable         allows new frames to start
//   cts_n          clear-to-send from the far end, active-low
//   gap_cycles     idle clocks inserted after each completed frame
//   fifo_empty     TX FIFO empty flag
//   fifo_r_data    TX FIFO head word, valid while not empty
//   fifo_rd        one-cycle pop strobe to the FIFO
//   tx_start       one-cycle frame launch strobe to the serializer
//   tx_din         registered word for the serializer, held between loads
//   tx_done_tick   end-of-frame pulse from the serializer
//   busy           high whenever a frame or gap is in progress
//   frame_cnt      frames completed since reset, wrapping
module uart_tx_sched #(
  parameter int unsigned B     = 8,
  parameter int unsigned GAP_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cts_n,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             fifo_empty,
  input  logic [B-1:0]     fifo_r_data,
  output logic             fifo_rd,
  output logic             tx_start,
  output logic [B-1:0]     tx_din,
  input  logic             tx_done_tick,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitDone,
    StGap
  } state_e;

  state_e             state_q, state_d;
  logic [B-1:0]       din_q, din_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               go;

  // enable and cts_n only matter here, so they are effectively sampled in idle.
  assign go = enable & ~cts_n & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      din_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    fifo_rd  = 1'b0;
    tx_start = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          fifo_rd = 1'b1;
          din_d   = fifo_r_data;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_start = 1'b1;
        state_d  = StWaitDone;
      end
      StWaitDone: begin
        if (tx_done_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          // Gap length is latched here so later input changes hit the next frame only.
          gap_d = gap_cycles;
          if (gap_cycles != '0) begin
            state_d = StGap;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        gap_d = gap_q - GAP_W'(1);
        // Leaving when the count hits zero gives exactly gap_cycles cycles in this state.
        if (gap_q == GAP_W'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // While reset is held the state may read idle with go true; suppress strobes.
    if (rst) begin
      fifo_rd  = 1'b0;
      tx_start = 1'b0;
    end
  end

  assign busy      = (state_q != StIdle) & ~rst;
  assign tx_din    = din_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int unsigned B     = 8;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             cts_n;
  logic [GAP_W-1:0] gap_cycles;
  logic             fifo_empty;
  logic [B-1:0]     fifo_r_data;
  logic             fifo_rd;
  logic             tx_start;
  logic [B-1:0]     tx_din;
  logic             tx_done_tick;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .B    (B),
    .GAP_W(GAP_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cts_n       (cts_n),
    .gap_cycles  (gap_cycles),
    .fifo_empty  (fifo_empty),
    .fifo_r_data (fifo_r_data),
    .fifo_rd     (fifo_rd),
    .tx_start    (tx_start),
    .tx_din      (tx_din),
    .tx_done_tick(tx_done_tick),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  // FWFT FIFO model
  logic [B-1:0] fmem [0:63];
  int           wr_ptr;
  int           rd_ptr;
  logic         flush;

  assign fifo_empty  = (rd_ptr == wr_ptr);
  assign fifo_r_data = fmem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd) rd_ptr <= rd_ptr + 1;
  end

  task automatic push(input logic [B-1:0] w);
    fmem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Serializer model: done pulse 10 cycles after the launch cycle
  int   tx_cnt;
  logic man_done;

  always @(posedge clk) begin
    if (tx_start) tx_cnt <= 10;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end

  assign tx_done_tick = (tx_cnt == 1) | man_done;

  // Event logs, sampled mid-cycle
  int           cyc;
  int           rd_log[$];
  int           st_log[$];
  int           dn_log[$];
  logic [B-1:0] wd_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_rd) rd_log.push_back(cyc);
    if (tx_start) begin
      st_log.push_back(cyc);
      wd_log.push_back(tx_din);
    end
    if (tx_done_tick) dn_log.push_back(cyc);
  end

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    int n;
    int b_rd;
    int b_st;
    int b_dn;
    bit ok;

    rst        = 1'b1;
    enable     = 1'b1;
    cts_n      = 1'b0;
    gap_cycles = '0;
    man_done   = 1'b0;
    flush      = 1'b0;

    // 1: reset with a word waiting and go true
    push(8'hA5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t1_fifo_rd", fifo_rd, 0);
    check_eq("t1_tx_start", tx_start, 0);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_frame_cnt", frame_cnt, 0);
    check_eq("t1_tx_din", tx_din, 0);
    @(posedge clk); #1;
    enable = 1'b0;
    flush  = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    rst   = 1'b0;

    // 2: single word, no gap
    @(posedge clk); #1;
    b_rd = rd_log.size(); b_st = st_log.size(); b_dn = dn_log.size();
    push(8'h3C);
    enable = 1'b1;
    n = cyc;
    @(negedge clk);
    check_eq("t2_rd_same_cycle", fifo_rd, 1);
    repeat (12) @(negedge clk);
    check_eq("t2_pops", rd_log.size() - b_rd, 1);
    check_eq("t2_start_cycle", st_log[b_st], n + 1);
    check_eq("t2_tx_din", wd_log[b_st], 8'h3C);
    check_eq("t2_done_cycle", dn_log[b_dn], n + 11);
    check_eq("t2_frame_cnt", frame_cnt, 1);
    check_eq("t2_busy_after", busy, 0);

    // 3: three words back to back, gap of 4
    @(posedge clk); #1;
    b_rd = rd_log.size(); b_st = st_log.size(); b_dn = dn_log.size();
    gap_cycles = 8'd4;
    push(8'h01); push(8'h02); push(8'h03);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dn_log.size() >= b_dn + 3 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("t3_complete", ok, 1);
    check_eq("t3_pops", rd_log.size() - b_rd, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t3_word%0d", i), wd_log[b_st + i], i + 1);
    end
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("t3_spacing%0d", i), rd_log[b_rd + i + 1] - dn_log[b_dn + i], 5);
    end
    check_eq("t3_frame_cnt", frame_cnt, 4);

    // 4: flow control
    @(posedge clk); #1;
    b_rd = rd_log.size(); b_st = st_log.size();
    cts_n      = 1'b1;
    gap_cycles = '0;
    push(8'h55); push(8'h66);
    repeat (50) @(negedge clk);
    check_eq("t4_blocked_pops", rd_log.size() - b_rd, 0);
    check_eq("t4_blocked_busy", busy, 0);
    @(posedge clk); #1;
    cts_n = 1'b0;
    @(negedge clk);
    check_eq("t4_rd_on_cts", fifo_rd, 1);
    repeat (2) @(posedge clk); #1;
    cts_n = 1'b1;  // lands in the wait-for-done phase
    repeat (30) @(negedge clk);
    check_eq("t4_one_pop", rd_log.size() - b_rd, 1);
    check_eq("t4_word", wd_log[b_st], 8'h55);
    check_eq("t4_frame_cnt", frame_cnt, 5);
    check_eq("t4_busy_end", busy, 0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cts_n = 1'b0;

    // 5: reset mid-frame, stray done afterwards
    @(posedge clk); #1;
    b_rd = rd_log.size(); b_st = st_log.size();
    push(8'h77);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_busy_in_rst", busy, 0);
    check_eq("t5_start_in_rst", tx_start, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("t5_frame_cnt", frame_cnt, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_pops", rd_log.size() - b_rd, 1);
    check_eq("t5_starts", st_log.size() - b_st, 1);
    @(posedge clk); #1;
    push(8'h88);
    @(negedge clk);
    check_eq("t5_go_again", fifo_rd, 1);
    repeat (13) @(negedge clk);
    check_eq("t5_frame_after", frame_cnt, 1);

    // 6: 17 frames on a 4-bit counter
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    b_rd = rd_log.size(); b_st = st_log.size(); b_dn = dn_log.size();
    for (int i = 0; i < 17; i++) push(8'(i + 8'h40));
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (dn_log.size() >= b_dn + 17 && !busy && fifo_empty) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("t6_complete", ok, 1);
    check_eq("t6_frame_cnt", frame_cnt, 1);
    check_eq("t6_pops", rd_log.size() - b_rd, 17);
    check_eq("t6_starts", st_log.size() - b_st, 17);
    check_eq("t6_dones", dn_log.size() - b_dn, 17);
    check_eq("t6_last_word", wd_log[b_st + 16], 8'h50);
    @(posedge clk); #1;
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    @(negedge clk);
    check_eq("t6_stray_done", frame_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
